// File: rtl/cnn_layer_seq.sv
// cnn_layer_seq: single-scan control sequencer for one CNN layer.
// Steps output pixels and kernel taps with counters. For each tap it
// generates a feature-RAM read (or a zero-pad flag). MAC strobes follow the
// reads by one cycle to cover the RAM read latency, and a bias/write strobe
// ends each output pixel. Conv mode is KxK stride-1 with a PAD border;
// affine mode is one dot product over AFF_N inputs.
module cnn_layer_seq #(
  parameter int IMG_H  = 4,
  parameter int IMG_W  = 3,
  parameter int K      = 3,
  parameter int PAD    = 1,
  parameter int AFF_N  = 12,
  parameter int ADDR_W = 9
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_mode,
  input  logic              i_out_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_acc_clr,
  output logic              o_acc_en,
  output logic              o_acc_zero,
  output logic              o_acc_last,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr
);

  localparam int OUT_H = IMG_H + 2*PAD - K + 1;
  localparam int OUT_W = IMG_W + 2*PAD - K + 1;
  localparam int KK    = K * K;
  // Two spare bits give the tap coordinates room to go negative in the
  // padding border without aliasing onto valid addresses.
  localparam int SW    = ADDR_W + 2;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_TAP, S_DRAIN, S_BIAS, S_DONE
  } state_t;

  state_t            r_state, w_next;
  logic              r_mode;
  logic [ADDR_W-1:0] r_oy, r_ox, r_ky, r_kx, r_tap;
  logic              r_acc_en, r_acc_zero, r_acc_clr, r_acc_last;

  logic signed [SW-1:0] w_iy, w_ix;
  logic                 w_inb, w_pad, w_last_tap, w_last_px;

  // Input-map coordinate of the current tap. It is signed because the
  // padding border sits at negative coordinates.
  assign w_iy = $signed({2'b00, r_oy}) + $signed({2'b00, r_ky}) - $signed(SW'(PAD));
  assign w_ix = $signed({2'b00, r_ox}) + $signed({2'b00, r_kx}) - $signed(SW'(PAD));
  assign w_inb = !w_iy[SW-1] && (w_iy < $signed(SW'(IMG_H))) &&
                 !w_ix[SW-1] && (w_ix < $signed(SW'(IMG_W)));
  // Affine taps never pad.
  assign w_pad = !r_mode && !w_inb;

  assign w_last_tap = r_mode ? (r_tap == ADDR_W'(AFF_N - 1))
                             : (r_tap == ADDR_W'(KK - 1));
  // An affine pass is always a single output.
  assign w_last_px  = r_mode || ((r_oy == ADDR_W'(OUT_H - 1)) &&
                                 (r_ox == ADDR_W'(OUT_W - 1)));

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic and state-decoded strobes.
  always_comb begin
    w_next    = r_state;
    o_busy    = (r_state != S_IDLE);
    o_done    = 1'b0;
    o_rd_en   = 1'b0;
    o_rd_addr = '0;
    o_wr_en   = 1'b0;
    o_wr_addr = '0;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_WAIT;
      S_WAIT:  if (i_out_ready) w_next = S_TAP;
      S_TAP: begin
        o_rd_en = !w_pad;
        if (r_mode)      o_rd_addr = r_tap;
        else if (!w_pad) o_rd_addr = w_iy[ADDR_W-1:0] * ADDR_W'(IMG_W) + w_ix[ADDR_W-1:0];
        if (w_last_tap) w_next = S_DRAIN;
      end
      S_DRAIN: w_next = S_BIAS;
      S_BIAS: begin
        o_wr_en = 1'b1;
        if (!r_mode) o_wr_addr = r_oy * ADDR_W'(OUT_W) + r_ox;
        w_next = w_last_px ? S_DONE : S_WAIT;
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Mode latch plus pixel and tap counters. Kernel taps scan ky outer, kx inner.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mode <= 1'b0;
      r_oy   <= '0;
      r_ox   <= '0;
      r_ky   <= '0;
      r_kx   <= '0;
      r_tap  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_mode <= i_mode;
          r_oy   <= '0;
          r_ox   <= '0;
          r_ky   <= '0;
          r_kx   <= '0;
          r_tap  <= '0;
        end
        S_TAP: begin
          if (w_last_tap) begin
            r_tap <= '0;
            r_ky  <= '0;
            r_kx  <= '0;
          end else begin
            r_tap <= r_tap + 1'b1;
            if (r_kx == ADDR_W'(K - 1)) begin
              r_kx <= '0;
              r_ky <= r_ky + 1'b1;
            end else begin
              r_kx <= r_kx + 1'b1;
            end
          end
        end
        S_BIAS: begin
          if (r_ox == ADDR_W'(OUT_W - 1)) begin
            r_ox <= '0;
            r_oy <= r_oy + 1'b1;
          end else begin
            r_ox <= r_ox + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Tap flags are delayed one cycle so each MAC strobe lines up with the
  // RAM data it consumes. The last one therefore lands in DRAIN.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc_en   <= 1'b0;
      r_acc_zero <= 1'b0;
      r_acc_clr  <= 1'b0;
      r_acc_last <= 1'b0;
    end else begin
      r_acc_en   <= (r_state == S_TAP);
      r_acc_zero <= (r_state == S_TAP) && w_pad;
      r_acc_clr  <= (r_state == S_TAP) && (r_tap == '0);
      r_acc_last <= (r_state == S_TAP) && w_last_tap;
    end
  end

  assign o_acc_en   = r_acc_en;
  assign o_acc_zero = r_acc_zero;
  assign o_acc_clr  = r_acc_clr;
  assign o_acc_last = r_acc_last;

endmodule

// File: tb/tb_cnn_layer_seq.sv
// Bench for cnn_layer_seq. It drives a default-parameter instance and a
// 5x5 / PAD=0 instance. Each cycle of a pass is compared against a trace
// built from the pixel / tap schedule.
module tb_cnn_layer_seq;
  localparam int AW = 9;

  logic clk = 1'b0, rst = 1'b1, start0 = 1'b0, start1 = 1'b0, mode = 1'b0, rdy = 1'b1;
  logic d0_busy, d0_done, d0_rd_en, d0_acc_clr, d0_acc_en, d0_acc_zero, d0_acc_last, d0_wr_en;
  logic d1_busy, d1_done, d1_rd_en, d1_acc_clr, d1_acc_en, d1_acc_zero, d1_acc_last, d1_wr_en;
  logic [AW-1:0] d0_rd_addr, d0_wr_addr, d1_rd_addr, d1_wr_addr;

  always #5 clk = ~clk;

  cnn_layer_seq dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start0), .i_mode(mode), .i_out_ready(rdy),
    .o_busy(d0_busy), .o_done(d0_done), .o_rd_en(d0_rd_en), .o_rd_addr(d0_rd_addr),
    .o_acc_clr(d0_acc_clr), .o_acc_en(d0_acc_en), .o_acc_zero(d0_acc_zero),
    .o_acc_last(d0_acc_last), .o_wr_en(d0_wr_en), .o_wr_addr(d0_wr_addr));

  cnn_layer_seq #(.IMG_H(5), .IMG_W(5), .K(3), .PAD(0)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .i_mode(mode), .i_out_ready(rdy),
    .o_busy(d1_busy), .o_done(d1_done), .o_rd_en(d1_rd_en), .o_rd_addr(d1_rd_addr),
    .o_acc_clr(d1_acc_clr), .o_acc_en(d1_acc_en), .o_acc_zero(d1_acc_zero),
    .o_acc_last(d1_acc_last), .o_wr_en(d1_wr_en), .o_wr_addr(d1_wr_addr));

  typedef struct packed {
    logic busy, done, rd_en;
    logic [AW-1:0] rd_addr;
    logic acc_clr, acc_en, acc_zero, acc_last, wr_en;
    logic [AW-1:0] wr_addr;
  } obs_t;

  int   n_chk = 0, n_pass = 0;
  obs_t exp_q[$];
  bit   rdy_q[$];
  int   stalls[32];
  int   rd_tag[$], rd_adr[$], zero_tag[$], wr_adr[$];
  int   done_c, n_done, busy_fall;

  function automatic obs_t samp(bit sel);
    if (sel) return {d1_busy, d1_done, d1_rd_en, d1_rd_addr, d1_acc_clr, d1_acc_en,
                     d1_acc_zero, d1_acc_last, d1_wr_en, d1_wr_addr};
    return {d0_busy, d0_done, d0_rd_en, d0_rd_addr, d0_acc_clr, d0_acc_en,
            d0_acc_zero, d0_acc_last, d0_wr_en, d0_wr_addr};
  endfunction

  // Reference schedule. Each pixel takes (stall+1) WAIT cycles, T tap reads,
  // one DRAIN and one BIAS cycle. Every MAC strobe describes the previous
  // tap. The pass ends with DONE and then IDLE.
  function automatic void build_trace(bit sel, bit m, bit noise);
    int h, w, k, p, oh, ow, npix, tn;
    obs_t e;
    h = sel ? 5 : 4;  w = sel ? 5 : 3;  k = 3;  p = sel ? 0 : 1;
    oh = h + 2*p - k + 1;  ow = w + 2*p - k + 1;
    npix = m ? 1 : oh * ow;
    tn = m ? 12 : k * k;
    exp_q.delete(); rdy_q.delete();
    for (int px = 0; px < npix; px++) begin
      bit padv[$];
      int adr[$];
      padv.delete(); adr.delete();
      for (int t = 0; t < tn; t++) begin
        int iy, ix;
        bit pd;
        iy = px / ow + t / k - p;
        ix = px % ow + t % k - p;
        pd = !m && (iy < 0 || iy >= h || ix < 0 || ix >= w);
        padv.push_back(pd);
        adr.push_back(m ? t : (pd ? 0 : iy * w + ix));
      end
      for (int s = 0; s < stalls[px]; s++) begin
        e = '0; e.busy = 1'b1; exp_q.push_back(e); rdy_q.push_back(1'b0);
      end
      e = '0; e.busy = 1'b1; exp_q.push_back(e); rdy_q.push_back(1'b1);
      for (int j = 0; j < tn; j++) begin
        e = '0; e.busy = 1'b1;
        e.rd_en = !padv[j];
        e.rd_addr = AW'(adr[j]);
        if (j > 0) begin
          e.acc_en = 1'b1; e.acc_zero = padv[j-1]; e.acc_clr = (j == 1);
        end
        exp_q.push_back(e);
        rdy_q.push_back(noise ? 1'($urandom_range(1)) : 1'b1);
      end
      e = '0; e.busy = 1'b1; e.acc_en = 1'b1; e.acc_zero = padv[tn-1];
      e.acc_clr = (tn == 1); e.acc_last = 1'b1;
      exp_q.push_back(e); rdy_q.push_back(noise ? 1'($urandom_range(1)) : 1'b1);
      e = '0; e.busy = 1'b1; e.wr_en = 1'b1; e.wr_addr = m ? '0 : AW'(px);
      exp_q.push_back(e); rdy_q.push_back(noise ? 1'($urandom_range(1)) : 1'b1);
    end
    e = '0; e.busy = 1'b1; e.done = 1'b1; exp_q.push_back(e); rdy_q.push_back(1'b1);
    e = '0; exp_q.push_back(e); rdy_q.push_back(1'b1);
  endfunction

  function automatic string rd_list(int tag);
    string s = "";
    foreach (rd_tag[i]) if (rd_tag[i] == tag) begin
      if (s == "") s = $sformatf("%0d", rd_adr[i]);
      else         s = {s, ",", $sformatf("%0d", rd_adr[i])};
    end
    return s;
  endfunction

  function automatic string wr_list();
    string s = "";
    foreach (wr_adr[i]) begin
      if (s == "") s = $sformatf("%0d", wr_adr[i]);
      else         s = {s, ",", $sformatf("%0d", wr_adr[i])};
    end
    return s;
  endfunction

  function automatic string seq_str(int n);
    string s = "0";
    for (int i = 1; i < n; i++) s = {s, ",", $sformatf("%0d", i)};
    return s;
  endfunction

  // Start at cycle t (the first negedge), then compare every cycle
  // t+1..end. A nonzero abort_at asserts rst during that cycle and stops.
  task automatic run_pass(bit sel, bit m, bit noise, int abort_at);
    obs_t o;
    int px;
    build_trace(sel, m, noise);
    rd_tag.delete(); rd_adr.delete(); zero_tag.delete(); wr_adr.delete();
    done_c = -1; n_done = 0; busy_fall = -1; px = 0;
    @(negedge clk);
    o = samp(sel);
    n_chk++;
    if (o !== '0) $display("FAIL idle_before_start: got %h expected 0", o);
    else n_pass++;
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    mode = m; rdy = 1'b1;
    for (int c = 1; c <= exp_q.size(); c++) begin
      @(negedge clk);
      o = samp(sel);
      n_chk++;
      if (o !== exp_q[c-1]) $display("FAIL trace sel=%0d mode=%0d cycle t+%0d: got %h expected %h", sel, m, c, o, exp_q[c-1]);
      else n_pass++;
      if (o.rd_en) begin rd_tag.push_back(px); rd_adr.push_back(int'(o.rd_addr)); end
      if (o.acc_en && o.acc_zero) zero_tag.push_back(px);
      if (o.wr_en) begin wr_adr.push_back(int'(o.wr_addr)); px++; end
      if (o.done) begin n_done++; if (done_c < 0) done_c = c; end
      if (!o.busy && busy_fall < 0 && done_c >= 0) busy_fall = c;
      if (sel) start1 = noise && c < exp_q.size() ? 1'($urandom_range(1)) : 1'b0;
      else     start0 = noise && c < exp_q.size() ? 1'($urandom_range(1)) : 1'b0;
      mode = noise ? 1'($urandom_range(1)) : m;
      rdy  = rdy_q[c-1];
      if (c == abort_at) begin rst = 1'b1; break; end
    end
    start0 = 1'b0; start1 = 1'b0;
  endtask

  task automatic clear_stalls();
    foreach (stalls[i]) stalls[i] = 0;
  endtask

  task automatic test_reset();
    obs_t o;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    o = samp(0); n_chk++;
    if (o !== '0) $display("FAIL reset_dut0: got %h expected 0", o); else n_pass++;
    o = samp(1); n_chk++;
    if (o !== '0) $display("FAIL reset_dut1: got %h expected 0", o); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_conv();
    clear_stalls();
    run_pass(0, 0, 0, 0);
    n_chk++; if (done_c !== 145) $display("FAIL conv_done_cycle: got %0d expected 145", done_c); else n_pass++;
    n_chk++; if (n_done !== 1) $display("FAIL conv_done_count: got %0d expected 1", n_done); else n_pass++;
    n_chk++; if (busy_fall !== 146) $display("FAIL conv_busy_fall: got %0d expected 146", busy_fall); else n_pass++;
    n_chk++; if (wr_list() != seq_str(12)) $display("FAIL conv_wr_addrs: got %s expected %s", wr_list(), seq_str(12)); else n_pass++;
    n_chk++; if (rd_list(0) != "0,1,3,4") $display("FAIL conv_px0_reads: got %s expected 0,1,3,4", rd_list(0)); else n_pass++;
    n_chk++;
    begin
      int nz = 0;
      foreach (zero_tag[i]) if (zero_tag[i] == 0) nz++;
      if (nz !== 5) $display("FAIL conv_px0_pads: got %0d expected 5", nz); else n_pass++;
    end
    n_chk++; if (rd_list(4) != seq_str(9)) $display("FAIL conv_px4_reads: got %s expected %s", rd_list(4), seq_str(9)); else n_pass++;
  endtask

  task automatic test_affine();
    clear_stalls();
    run_pass(0, 1, 0, 0);
    n_chk++; if (done_c !== 16) $display("FAIL aff_done_cycle: got %0d expected 16", done_c); else n_pass++;
    n_chk++; if (rd_list(0) != seq_str(12)) $display("FAIL aff_reads: got %s expected %s", rd_list(0), seq_str(12)); else n_pass++;
    n_chk++; if (wr_list() != "0") $display("FAIL aff_wr: got %s expected 0", wr_list()); else n_pass++;
  endtask

  task automatic test_backpressure();
    clear_stalls();
    stalls[3] = 5;
    run_pass(0, 0, 1, 0);
    n_chk++; if (done_c !== 150) $display("FAIL bp_done_cycle: got %0d expected 150", done_c); else n_pass++;
    n_chk++; if (n_done !== 1) $display("FAIL bp_done_count: got %0d expected 1", n_done); else n_pass++;
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int bad = 0;
    clear_stalls();
    run_pass(0, 0, 0, 40);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      o = samp(0); n_chk++;
      if (o !== '0) begin bad++; $display("FAIL rst_mid_quiet t+%0d: got %h expected 0", 41 + i, o); end
      else n_pass++;
    end
    rst = 1'b0;
    run_pass(0, 0, 0, 0);
    n_chk++; if (done_c !== 145) $display("FAIL rst_restart_done: got %0d expected 145", done_c); else n_pass++;
  endtask

  task automatic test_ignore_start();
    obs_t o;
    clear_stalls();
    run_pass(0, 0, 1, 0);
    n_chk++; if (n_done !== 1) $display("FAIL ign_done_count: got %0d expected 1", n_done); else n_pass++;
    n_chk++; if (rd_list(0) != "0,1,3,4") $display("FAIL ign_px0_reads: got %s expected 0,1,3,4", rd_list(0)); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      o = samp(0); n_chk++;
      if (o !== '0) $display("FAIL ign_no_second_pass +%0d: got %h expected 0", i, o); else n_pass++;
    end
  endtask

  task automatic test_variant();
    clear_stalls();
    run_pass(1, 0, 0, 0);
    n_chk++; if (wr_list() != seq_str(9)) $display("FAIL var_wr_addrs: got %s expected %s", wr_list(), seq_str(9)); else n_pass++;
    n_chk++; if (zero_tag.size() !== 0) $display("FAIL var_no_pad: got %0d expected 0", zero_tag.size()); else n_pass++;
    n_chk++; if (rd_list(0) != "0,1,2,5,6,7,10,11,12") $display("FAIL var_px0_reads: got %s expected 0,1,2,5,6,7,10,11,12", rd_list(0)); else n_pass++;
    n_chk++; if (done_c !== 109) $display("FAIL var_done_cycle: got %0d expected 109", done_c); else n_pass++;
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      bit sel, m;
      sel = (r >= 4);
      m = 1'($urandom_range(1));
      foreach (stalls[i]) stalls[i] = $urandom_range(3);
      run_pass(sel, m, 1, 0);
      n_chk++; if (n_done !== 1) $display("FAIL rand_done_count r=%0d: got %0d expected 1", r, n_done); else n_pass++;
    end
  endtask

  initial begin
    clear_stalls();
    test_reset();
    test_conv();
    test_affine();
    test_backpressure();
    test_reset_mid();
    test_ignore_start();
    test_variant();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
